// File: rtl/cmos_frame_capture.sv
// OV7670 byte-stream capture: assembles camera byte pairs into 12-bit RGB444
// pixels (RGB565 / RGB444 / YUYV-grey sources), optional 2:1 decimation,
// single-shot or continuous framing, frame counting and overrun flagging.
module cmos_frame_capture #(
  parameter int ACTIVE_COLUMNS  = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int VRAM_ADDR_WIDTH = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       byte_valid_i,
  input  logic                       vsync_cmos_i,
  input  logic                       href_cmos_i,
  input  logic [7:0]                 pixel_data_cmos_i,
  input  logic                       start_i,
  input  logic                       continuous_i,
  input  logic [1:0]                 mode_i,
  input  logic                       decimate_i,
  output logic                       wr_en_o,
  output logic [VRAM_ADDR_WIDTH-1:0] wr_addr_o,
  output logic [11:0]                wr_data_o,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic [15:0]                frame_count_o,
  output logic                       overrun_o
);
  localparam int AW = VRAM_ADDR_WIDTH;
  localparam int CW = $clog2(ACTIVE_COLUMNS+1);
  localparam int RW = $clog2(ACTIVE_ROWS+1);
  // Counters saturate at the window size so a long row/frame can never wrap
  // back into the window.
  localparam logic [CW-1:0] COL_END    = CW'(ACTIVE_COLUMNS);
  localparam logic [RW-1:0] ROW_END    = RW'(ACTIVE_ROWS);
  localparam logic [AW-1:0] STRIDE     = AW'(ACTIVE_COLUMNS);
  localparam logic [AW-1:0] STRIDE_DEC = AW'(ACTIVE_COLUMNS/2);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_t;
  state_t state, state_nxt;

  logic          vsync_q, href_q;
  logic [1:0]    mode_r;
  logic          dec_r;
  logic          phase;
  logic [7:0]    b0;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] addr, row_base, row_base_nxt;
  logic          vsync_rise, vsync_fall, href_fall;
  logic          byte_take, in_win, row_kept, keep_pix;
  logic [11:0]   pix;

  assign vsync_rise = vsync_cmos_i & ~vsync_q;
  assign vsync_fall = ~vsync_cmos_i & vsync_q;
  assign href_fall  = ~href_cmos_i & href_q;
  // The byte coinciding with href falling still belongs to the ending row.
  assign byte_take  = (state == S_CAPTURE) & byte_valid_i & (href_cmos_i | href_q);
  assign in_win     = (col < COL_END) && (row < ROW_END);
  assign row_kept   = ~dec_r | ~row[0];
  assign keep_pix   = in_win & (~dec_r | (~col[0] & ~row[0]));
  // Skipped (odd) rows of a decimated frame occupy no VRAM.
  assign row_base_nxt = row_base + (dec_r ? (row_kept ? STRIDE_DEC : AW'(0)) : STRIDE);
  assign busy_o     = (state == S_ARM) || (state == S_CAPTURE);

  // Pixel assembly from the stored first byte and the current second byte.
  always_comb begin
    pix = {b0[3:0], pixel_data_cmos_i};
    case (mode_r)
      2'd0:    pix = {b0[7:4], b0[2:0], pixel_data_cmos_i[7], pixel_data_cmos_i[4:1]};
      2'd2:    pix = {3{b0[7:4]}};
      default: pix = {b0[3:0], pixel_data_cmos_i};
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state: frames are only entered on a vsync falling edge.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_i | continuous_i) state_nxt = S_ARM;
      S_ARM:     if (vsync_fall) state_nxt = S_CAPTURE;
      S_CAPTURE: if (vsync_rise) state_nxt = S_DONE;
      S_DONE:    state_nxt = continuous_i ? S_ARM : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath: edge history, counters, incremental addressing, write port.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      vsync_q <= 1'b0; href_q <= 1'b0;
      mode_r <= 2'd0; dec_r <= 1'b0;
      phase <= 1'b0; b0 <= 8'd0;
      col <= '0; row <= '0; addr <= '0; row_base <= '0;
      wr_en_o <= 1'b0; wr_addr_o <= '0; wr_data_o <= 12'd0;
      frame_done_o <= 1'b0; frame_count_o <= 16'd0; overrun_o <= 1'b0;
    end else begin
      vsync_q      <= vsync_cmos_i;
      href_q       <= href_cmos_i;
      wr_en_o      <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        S_IDLE, S_ARM: begin
          mode_r <= mode_i; dec_r <= decimate_i;
          phase <= 1'b0; col <= '0; row <= '0; addr <= '0; row_base <= '0;
          if (state == S_IDLE && (start_i | continuous_i)) overrun_o <= 1'b0;
        end
        S_CAPTURE: begin
          if (byte_take) begin
            phase <= ~phase;
            if (!phase) b0 <= pixel_data_cmos_i;
            else begin
              if (col != COL_END) col <= col + CW'(1);
              if (keep_pix) begin
                wr_en_o   <= 1'b1;
                wr_addr_o <= addr;
                wr_data_o <= pix;
                addr      <= addr + AW'(1);
              end else if (!in_win) begin
                overrun_o <= 1'b1;
              end
            end
          end
          // Row end overrides the byte update; a half pixel is discarded.
          if (href_fall) begin
            phase <= 1'b0;
            col   <= '0;
            if (row != ROW_END) row <= row + RW'(1);
            addr     <= row_base_nxt;
            row_base <= row_base_nxt;
          end
        end
        S_DONE: begin
          frame_done_o  <= 1'b1;
          frame_count_o <= frame_count_o + 16'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cmos_frame_capture.sv
// Self-checking bench for cmos_frame_capture on a 4x4 window with random
// byte streams and a frame-level reference model.
module tb_cmos_frame_capture;
  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int AW   = 4;

  logic          clk, reset, bv, vsync, href, start, cont, dec;
  logic [7:0]    data;
  logic [1:0]    mode;
  logic          wr_en, busy, frame_done, overrun;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [15:0]   frame_count;

  cmos_frame_capture #(.ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .VRAM_ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .reset_i(reset), .byte_valid_i(bv), .vsync_cmos_i(vsync),
    .href_cmos_i(href), .pixel_data_cmos_i(data), .start_i(start),
    .continuous_i(cont), .mode_i(mode), .decimate_i(dec),
    .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .busy_o(busy),
    .frame_done_o(frame_done), .frame_count_o(frame_count), .overrun_o(overrun));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    fb [8][16];
  int            rl [8];
  int            nrows;
  int            cur_row;
  logic [AW-1:0] got_a[$], exp_a[$];
  logic [11:0]   got_d[$], exp_d[$];
  bit            exp_ovr;
  int            done_cnt;
  int            n_cmp, n_bad;

  // Write/pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin got_a.push_back(wr_addr); got_d.push_back(wr_data); end
    if (frame_done === 1'b1) done_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference pixel: unpack the source format into channels, keep top 4 bits.
  function automatic logic [11:0] ref_pix(input int m, input logic [7:0] b0, input logic [7:0] b1);
    int r, g, b;
    if (m == 0) begin
      r = int'(b0 >> 3) >> 1;
      g = ((int'(b0 & 8'd7) << 3) | int'(b1 >> 5)) >> 2;
      b = int'(b1 & 8'd31) >> 1;
    end else if (m == 2) begin
      r = int'(b0 >> 4); g = r; b = r;
    end else begin
      r = int'(b0 & 8'd15); g = int'(b1 >> 4); b = int'(b1 & 8'd15);
    end
    return 12'(r*256 + g*16 + b);
  endfunction

  // Frame model: pixel p of row r lands at r*COLS+p, or packed at half
  // resolution when decimating; anything outside the window is an overrun.
  function automatic void build_expect(input int m, input bit d);
    for (int r = 0; r < nrows; r++)
      for (int p = 0; p < rl[r]/2; p++) begin
        if (p >= COLS || r >= ROWS) exp_ovr = 1'b1;
        else if (!d || (p%2 == 0 && r%2 == 0)) begin
          exp_a.push_back(AW'(d ? (r/2)*(COLS/2) + p/2 : r*COLS + p));
          exp_d.push_back(ref_pix(m, fb[r][2*p], fb[r][2*p+1]));
        end
      end
  endfunction

  task automatic clear_q();
    got_a.delete(); got_d.delete(); exp_a.delete(); exp_d.delete();
    exp_ovr = 1'b0; done_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; cont = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_q();
  endtask

  task automatic fill_rand(input int n, input int len);
    nrows = n;
    for (int r = 0; r < n; r++) begin
      rl[r] = len;
      for (int b = 0; b < len; b++) fb[r][b] = 8'($urandom);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  // One camera frame: blanking, rows with random byte gaps, then vsync high.
  task automatic drive_frame(input bit fall_last);
    cur_row = -1;
    vsync = 1'b1; repeat (3) @(negedge clk);
    vsync = 1'b0; repeat (2) @(negedge clk);
    for (int r = 0; r < nrows; r++) begin
      cur_row = r;
      href = 1'b1; @(negedge clk);
      for (int b = 0; b < rl[r]; b++) begin
        if (fall_last && b == rl[r]-1) href = 1'b0;
        data = fb[r][b]; bv = 1'b1; @(negedge clk); bv = 1'b0;
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      href = 1'b0; repeat (2) @(negedge clk);
    end
    vsync = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    n_cmp++; if (wr_addr !== '0) begin n_bad++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    n_cmp++; if (wr_data !== 12'd0) begin n_bad++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", frame_count); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    reset = 1'b0;
    clear_q();
  endtask

  task automatic test_rgb444();
    do_reset();
    mode = 2'd1; dec = 1'b0; nrows = 2;
    for (int r = 0; r < 2; r++) begin
      rl[r] = 8;
      for (int b = 0; b < 8; b++) fb[r][b] = (b % 2 == 1) ? 8'hBC : 8'h0A;
    end
    build_expect(1, 1'b0);
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rgb444_busy_armed: got %b want 1", busy); end
    drive_frame(1'b0);
    @(negedge clk);
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rgb444_done_early: got %b want 0", frame_done); end
    @(negedge clk);
    n_cmp++; if (frame_done !== 1'b1) begin n_bad++; $display("FAIL rgb444_done_latency: got %b want 1", frame_done); end
    @(negedge clk);
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rgb444_done_width: got %b want 0", frame_done); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL rgb444_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL rgb444_count: got %0d want 1", frame_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rgb444_busy_idle: got %b want 0", busy); end
    n_cmp++; if (got_a.size() != exp_a.size()) begin n_bad++; $display("FAIL rgb444_nwrites: got %0d want %0d", got_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL rgb444_write[%0d]: got %h@%0d want %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_formats();
    int modes[3] = '{0, 2, 3};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      mode = 2'(modes[k]); dec = 1'b0;
      fill_rand(2, 8);
      if (modes[k] == 0) begin fb[0][0] = 8'hF8; fb[0][1] = 8'h1F; end
      if (modes[k] == 2) fb[0][0] = 8'h9C;
      build_expect(modes[k], 1'b0);
      pulse_start();
      // Settings changed mid-frame must not affect the frame in flight.
      fork
        drive_frame(1'($urandom_range(0, 1)));
        begin repeat (10) @(negedge clk); mode = 2'($urandom_range(0, 3)); dec = 1'b1; end
      join
      repeat (4) @(negedge clk);
      n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL fmt%0d_count: got %0d want 1", modes[k], frame_count); end
      n_cmp++; if (got_a.size() != exp_a.size()) begin n_bad++; $display("FAIL fmt%0d_nwrites: got %0d want %0d", modes[k], got_a.size(), exp_a.size()); end
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
        n_cmp++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          n_bad++; $display("FAIL fmt%0d_write[%0d]: got %h@%0d want %h@%0d", modes[k], i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_decimate();
    int m;
    do_reset();
    m = $urandom_range(0, 3);
    mode = 2'(m); dec = 1'b1;
    fill_rand(4, 8);
    build_expect(m, 1'b1);
    pulse_start();
    drive_frame(1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (got_a.size() != 4) begin n_bad++; $display("FAIL dec_nwrites: got %0d want 4", got_a.size()); end
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL dec_overrun: got %b want 0", overrun); end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL dec_write[%0d]: got %h@%0d want %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    mode = 2'd1; dec = 1'b0;
    fill_rand(5, 8);
    rl[0] = 12; for (int b = 8; b < 12; b++) fb[0][b] = 8'($urandom);
    rl[1] = 3;
    build_expect(1, 1'b0);
    pulse_start();
    drive_frame(1'b1);
    repeat (4) @(negedge clk);
    n_cmp++; if (overrun !== exp_ovr) begin n_bad++; $display("FAIL ovr_flag: got %b want %b", overrun, exp_ovr); end
    n_cmp++; if (got_a.size() != exp_a.size()) begin n_bad++; $display("FAIL ovr_nwrites: got %0d want %0d", got_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL ovr_write[%0d]: got %h@%0d want %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
      end
    end
    // A fresh start clears the sticky flag.
    clear_q();
    fill_rand(2, 8);
    build_expect(1, 1'b0);
    pulse_start();
    drive_frame(1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_cleared: got %b want 0", overrun); end
    n_cmp++; if (got_a.size() != exp_a.size()) begin n_bad++; $display("FAIL ovr2_nwrites: got %0d want %0d", got_a.size(), exp_a.size()); end
  endtask

  task automatic test_continuous();
    int m;
    do_reset();
    m = $urandom_range(0, 3);
    mode = 2'(m); dec = 1'($urandom_range(0, 1));
    cont = 1'b1;
    fill_rand(4, 2*$urandom_range(1, 4));
    build_expect(m, dec);
    drive_frame(1'b0);
    fill_rand(4, 8);
    build_expect(m, dec);
    fork
      drive_frame(1'b0);
      begin repeat (12) @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0; end
    join
    fill_rand(3, 2*$urandom_range(1, 4));
    build_expect(m, dec);
    fork
      drive_frame(1'b1);
      begin repeat (12) @(negedge clk); cont = 1'b0; end
    join
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt != 3) begin n_bad++; $display("FAIL cont_done_cnt: got %0d want 3", done_cnt); end
    n_cmp++; if (frame_count !== 16'd3) begin n_bad++; $display("FAIL cont_count: got %0d want 3", frame_count); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_busy: got %b want 0", busy); end
    n_cmp++; if (got_a.size() != exp_a.size()) begin n_bad++; $display("FAIL cont_nwrites: got %0d want %0d", got_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL cont_write[%0d]: got %h@%0d want %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n_at;
    do_reset();
    mode = 2'd1; dec = 1'b0;
    fill_rand(4, 8);
    n_at = -1;
    pulse_start();
    fork
      drive_frame(1'b0);
      begin
        int budget;
        budget = 2000;
        while (cur_row != 1 && budget > 0) begin @(negedge clk); budget--; end
        n_cmp++;
        if (cur_row != 1) begin n_bad++; $display("FAIL rstmid_wait: got row %0d want 1", cur_row); end
        else begin
          repeat (3) @(negedge clk);
          reset = 1'b1; @(negedge clk); #1;
          n_at = got_a.size();
          n_cmp++; if (wr_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || overrun !== 1'b0)
            begin n_bad++; $display("FAIL rstmid_flags: got en=%b busy=%b done=%b ovr=%b want 0", wr_en, busy, frame_done, overrun); end
          n_cmp++; if (wr_addr !== '0 || wr_data !== 12'd0)
            begin n_bad++; $display("FAIL rstmid_bus: got %h@%0d want 0@0", wr_data, wr_addr); end
          reset = 1'b0;
        end
      end
    join
    repeat (5) @(negedge clk);
    n_cmp++; if (n_at >= 0 && got_a.size() != n_at) begin n_bad++; $display("FAIL rstmid_writes: got %0d want %0d", got_a.size(), n_at); end
    n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL rstmid_count: got %0d want 0", frame_count); end
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL rstmid_done: got %0d want 0", done_cnt); end
    // The next armed frame is captured in full.
    clear_q();
    fill_rand(4, 8);
    build_expect(1, 1'b0);
    pulse_start();
    drive_frame(1'b0);
    repeat (4) @(negedge clk);
    n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL rstmid_recount: got %0d want 1", frame_count); end
    n_cmp++; if (got_a.size() != exp_a.size()) begin n_bad++; $display("FAIL rstmid_nwrites: got %0d want %0d", got_a.size(), exp_a.size()); end
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
        n_bad++; $display("FAIL rstmid_write[%0d]: got %h@%0d want %h@%0d", i, got_d[i], got_a[i], exp_d[i], exp_a[i]);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; done_cnt = 0; cur_row = -1; nrows = 0;
    reset = 1'b1; bv = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'd0;
    start = 1'b0; cont = 1'b0; mode = 2'd1; dec = 1'b0;
    test_reset();
    test_rgb444();
    test_formats();
    test_decimate();
    test_overrun();
    test_continuous();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cmos_frame_capture.md
# cmos_frame_capture

Parametrised OV7670 capture engine. Converts the camera byte stream (vsync/href/8-bit data) into 12-bit RGB444 pixels and writes them to frame VRAM. Adds the following on top of the fixed 640x480 RGB444 path:
- run-time pixel format: RGB565, RGB444 or YUYV grey
- optional 2:1 decimation
- single-shot or continuous frame arming
- frame counter and overrun detection

It sits between the camera input synchroniser and the VRAM write port, inside the camera top level.

## Interface
Parameters:
- ACTIVE_COLUMNS, 640, pixels per camera row
- ACTIVE_ROWS, 480, rows per camera frame
- VRAM_ADDR_WIDTH, $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), write address width

Ports:
- clk_i  in  1  system clock; all inputs are synchronous to it
- reset_i  in  1  synchronous, active-high reset
- byte_valid_i  in  1  one-cycle strobe: pixel_data_cmos_i holds a new camera byte (upstream synchroniser, one per PCLK rise)
- vsync_cmos_i  in  1  camera vsync; high means vertical blanking
- href_cmos_i  in  1  camera href; high means active row
- pixel_data_cmos_i  in  8  camera byte
- start_i  in  1  arm capture of one frame
- continuous_i  in  1  re-arm automatically after each frame
- mode_i  in  2  format: 0 RGB565, 1 RGB444 (xR GB), 2 YUYV grey, 3 reserved (treated as 1)
- decimate_i  in  1  1 = keep even columns and even rows only
- wr_en_o  out  1  VRAM write strobe
- wr_addr_o  out  VRAM_ADDR_WIDTH  VRAM write address
- wr_data_o  out  12  pixel {R4,G4,B4}
- busy_o  out  1  state is ARM or CAPTURE
- frame_done_o  out  1  one-cycle pulse at end of a captured frame
- frame_count_o  out  16  completed frames, wraps at 0xFFFF->0
- overrun_o  out  1  sticky: pixel or row beyond active window was dropped

## Operation
- State IDLE:
  - start_i or continuous_i -> ARM.
  - Latch mode_i and decimate_i; clear overrun_o, the address, and the row and column counters.
- State ARM:
  - Wait for vsync_cmos_i high, then for vsync_cmos_i low.
  - On that falling edge -> CAPTURE. A frame is never entered mid-stream.
- State CAPTURE:
  - Byte phase toggles on each byte_valid_i while href_cmos_i is high.
  - Phase 0 stores b0. Phase 1 with b1 assembles a pixel:
    - RGB565: {b0[7:4], b0[2:0], b1[7], b1[4:1]}
    - RGB444: {b0[3:0], b1[7:0]}
    - grey: {b0[7:4], b0[7:4], b0[7:4]} (Y is the first byte)
  - Column counter increments per assembled pixel.
  - Write is issued when all of these hold:
    - col < ACTIVE_COLUMNS
    - row < ACTIVE_ROWS
    - decimation off, or col and row both even
  - An out-of-window pixel is not written and sets overrun_o.
  - href_cmos_i falling edge:
    - row++, col=0, phase=0.
    - An odd leftover byte is dropped silently.
    - Address jumps to the next row base: row_base += ACTIVE_COLUMNS, or ACTIVE_COLUMNS/2 when decimating and the row was kept. A short row therefore never shifts later rows.
  - Address is computed incrementally, no multiplier: +1 per write. The decimated image is packed at stride ACTIVE_COLUMNS/2.
  - vsync_cmos_i rising edge -> DONE.
- State DONE (one cycle):
  - frame_done_o=1, frame_count_o++.
  - -> ARM if continuous_i, else IDLE.
- start_i while busy is ignored. mode_i and decimate_i changes take effect only at the next IDLE/ARM latch.
- Dropping continuous_i mid-frame finishes the current frame, then goes to IDLE.

## Timing
- Reset: state IDLE. All outputs 0: wr_en_o, wr_addr_o, wr_data_o, busy_o, frame_done_o, frame_count_o, overrun_o. All counters 0.
- Write latency: wr_en_o/wr_addr_o/wr_data_o are registered and asserted in the cycle after the byte_valid_i carrying b1. wr_en_o is high for exactly one cycle.
- vsync/href edges are detected against a one-cycle delayed copy. The state change is visible the cycle after the edge sample.
- frame_done_o is asserted 2 cycles after the vsync_cmos_i sample that rises.
- A byte_valid_i in the same cycle as href falling is processed first; the row then ends.
- Reset mid-frame: the pending write is suppressed (wr_en_o=0 next cycle) and the frame is not counted.
- byte_valid_i may arrive on consecutive cycles. Full throughput is one pixel per two clocks.

## Test plan
- Reset, start_i pulse, one 4x2 frame in RGB444 (ACTIVE_COLUMNS=4, ACTIVE_ROWS=2), bytes 0x0A,0xBC repeated -> 8 writes with data 0xABC at addr 0..7, frame_done_o once, frame_count_o=1, busy_o=0.
- RGB565 b0=0xF8, b1=0x1F -> wr_data_o=0xF0F. Grey mode Y=0x9C -> 0x999.
- decimate_i=1, 4x4 frame -> exactly 4 writes at addr 0..3, taken from (col,row) (0,0),(2,0),(0,2),(2,2).
- Row of 6 pixels with ACTIVE_COLUMNS=4 -> 4 writes, overrun_o=1. The next row starts at addr 4. A 3-byte row drops the last byte with no write.
- continuous_i=1 for 3 frames -> frame_count_o=3 and 3 frame_done_o pulses. start_i mid-capture changes nothing.
- Assert reset_i during row 1 -> no further writes, all outputs 0, frame_count_o=0. A new start_i captures the next full frame.
